confidence_bank: RTL and testbench

CONFIDENCE_BANK -- requirements
Module: confidence_bank

---
 rtl/confidence_bank.sv | 165 ++++++++++++++++
 tb/tb_confidence_bank.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/confidence_bank.sv
// Per-channel black/white confidence accumulator bank with frame snapshot and best-channel scan.
// Define CONF_BANK_SAT_EN for saturating accumulators; by default they wrap modulo 2^ACC_W.
module confidence_bank #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned IN_W   = 10,
  parameter int unsigned ACC_W  = 16,
  localparam int unsigned SEL_W = $clog2(NUM_CH)
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             WE,
  input  logic [SEL_W-1:0] CH_SEL,
  input  logic [IN_W-1:0]  confidence_BLK,
  input  logic [IN_W-1:0]  confidence_WHT,
  input  logic             FRAME_END,
  input  logic [SEL_W-1:0] RD_SEL,
  output logic [ACC_W-1:0] confidence_BLK_out,
  output logic [ACC_W-1:0] confidence_WHT_out,
  output logic [SEL_W-1:0] BEST_CH,
  output logic [ACC_W:0]   BEST_SCORE,
  output logic             RESULT_VALID,
  input  logic             RESULT_READY,
  output logic             OVERRUN
);

  typedef enum logic [1:0] {StIdle, StScan, StHold} state_e;

  state_e           state_q, state_d;
  logic [SEL_W:0]   scan_idx_q, scan_idx_d;
  logic [SEL_W-1:0] best_ch_q, best_ch_d;
  logic [ACC_W:0]   best_score_q, best_score_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;

  logic [ACC_W-1:0] live_blk_q   [NUM_CH];
  logic [ACC_W-1:0] live_blk_d   [NUM_CH];
  logic [ACC_W-1:0] live_wht_q   [NUM_CH];
  logic [ACC_W-1:0] live_wht_d   [NUM_CH];
  logic [ACC_W-1:0] shadow_blk_q [NUM_CH];
  logic [ACC_W-1:0] shadow_blk_d [NUM_CH];
  logic [ACC_W-1:0] shadow_wht_q [NUM_CH];
  logic [ACC_W-1:0] shadow_wht_d [NUM_CH];

  logic             ch_ok;
  logic [SEL_W-1:0] scan_ch;
  logic [ACC_W:0]   scan_score;

  function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0] acc,
                                               input logic [IN_W-1:0]  smp);
`ifdef CONF_BANK_SAT_EN
    logic [ACC_W:0] sum;
    sum = {1'b0, acc} + (ACC_W+1)'(smp);
    return sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    return acc + ACC_W'(smp);
`endif
  endfunction

  assign ch_ok      = 32'(CH_SEL) < NUM_CH;
  assign scan_ch    = scan_idx_q[SEL_W-1:0];
  assign scan_score = {1'b0, shadow_blk_q[scan_ch]} + {1'b0, shadow_wht_q[scan_ch]};

  always_comb begin
    state_d      = state_q;
    scan_idx_d   = scan_idx_q;
    best_ch_d    = best_ch_q;
    best_score_d = best_score_q;
    valid_d      = valid_q;
    overrun_d    = overrun_q;
    live_blk_d   = live_blk_q;
    live_wht_d   = live_wht_q;
    shadow_blk_d = shadow_blk_q;
    shadow_wht_d = shadow_wht_q;

    for (int i = 0; i < NUM_CH; i++) begin
      if (WE && ch_ok && (CH_SEL == SEL_W'(i))) begin
        live_blk_d[i] = acc_add(live_blk_q[i], confidence_BLK);
        live_wht_d[i] = acc_add(live_wht_q[i], confidence_WHT);
      end
    end

    unique case (state_q)
      StIdle: begin
        // Snapshot includes this cycle's sample, then live bank is cleared below.
        if (FRAME_END) begin
          shadow_blk_d = live_blk_d;
          shadow_wht_d = live_wht_d;
          scan_idx_d   = '0;
          state_d      = StScan;
        end
      end
      StScan: begin
        if (FRAME_END) overrun_d = 1'b1;
        if (scan_idx_q == (SEL_W+1)'(NUM_CH)) begin
          state_d = StHold;
          valid_d = 1'b1;
        end else begin
          if ((scan_idx_q == '0) || (scan_score > best_score_q)) begin
            best_ch_d    = scan_ch;
            best_score_d = scan_score;
          end
          scan_idx_d = scan_idx_q + 1'b1;
        end
      end
      StHold: begin
        if (FRAME_END) overrun_d = 1'b1;
        if (RESULT_READY) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (FRAME_END) begin
      for (int i = 0; i < NUM_CH; i++) begin
        live_blk_d[i] = '0;
        live_wht_d[i] = '0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q      <= StIdle;
      scan_idx_q   <= '0;
      best_ch_q    <= '0;
      best_score_q <= '0;
      valid_q      <= 1'b0;
      overrun_q    <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        live_blk_q[i]   <= '0;
        live_wht_q[i]   <= '0;
        shadow_blk_q[i] <= '0;
        shadow_wht_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      scan_idx_q   <= scan_idx_d;
      best_ch_q    <= best_ch_d;
      best_score_q <= best_score_d;
      valid_q      <= valid_d;
      overrun_q    <= overrun_d;
      live_blk_q   <= live_blk_d;
      live_wht_q   <= live_wht_d;
      shadow_blk_q <= shadow_blk_d;
      shadow_wht_q <= shadow_wht_d;
    end
  end

  always_comb begin
    confidence_BLK_out = '0;
    confidence_WHT_out = '0;
    if (32'(RD_SEL) < NUM_CH) begin
      confidence_BLK_out = shadow_blk_q[RD_SEL];
      confidence_WHT_out = shadow_wht_q[RD_SEL];
    end
  end

  assign BEST_CH      = best_ch_q;
  assign BEST_SCORE   = best_score_q;
  assign RESULT_VALID = valid_q;
  assign OVERRUN      = overrun_q;

endmodule

// File: tb/tb_confidence_bank.sv
// Scoreboard bench for confidence_bank: directed scenarios plus random traffic against a
// frame-level reference model; results are queued at frame close and checked on RESULT_VALID.
module tb_confidence_bank;
  localparam int unsigned NUM_CH = 4;
  localparam int unsigned IN_W   = 10;
  localparam int unsigned ACC_W  = 16;
  localparam int unsigned SEL_W  = $clog2(NUM_CH);
  localparam longint ACC_MAX = (64'd1 << ACC_W) - 1;

  logic             CLK = 1'b0;
  logic             RESET_N, WE, FRAME_END, RESULT_READY;
  logic [SEL_W-1:0] CH_SEL, RD_SEL;
  logic [IN_W-1:0]  confidence_BLK, confidence_WHT;
  logic [ACC_W-1:0] confidence_BLK_out, confidence_WHT_out;
  logic [SEL_W-1:0] BEST_CH;
  logic [ACC_W:0]   BEST_SCORE;
  logic             RESULT_VALID, OVERRUN;

  always #5 CLK = ~CLK;

  confidence_bank #(.NUM_CH(NUM_CH), .IN_W(IN_W), .ACC_W(ACC_W)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .WE(WE), .CH_SEL(CH_SEL),
    .confidence_BLK(confidence_BLK), .confidence_WHT(confidence_WHT),
    .FRAME_END(FRAME_END), .RD_SEL(RD_SEL),
    .confidence_BLK_out(confidence_BLK_out), .confidence_WHT_out(confidence_WHT_out),
    .BEST_CH(BEST_CH), .BEST_SCORE(BEST_SCORE), .RESULT_VALID(RESULT_VALID),
    .RESULT_READY(RESULT_READY), .OVERRUN(OVERRUN)
  );

  typedef struct {int ch; longint score; longint due;} exp_t;
  exp_t   sb_q[$];
  exp_t   cur;
  bit     have_cur, seen_valid, mon_en;
  int     n_checks, n_errors;

  // Reference model: frame-level view (0 = waiting, 1 = evaluating, 2 = result offered)
  longint m_lblk[NUM_CH], m_lwht[NUM_CH], m_sblk[NUM_CH], m_swht[NUM_CH];
  int     m_phase, m_cnt;
  bit     m_valid, m_ovr;
  longint cyc;

  function automatic longint acc(input longint a, input longint s);
`ifdef CONF_BANK_SAT_EN
    return (a + s > ACC_MAX) ? ACC_MAX : a + s;
`else
    return (a + s) % (ACC_MAX + 1);
`endif
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_edge(input bit rstn, input bit we, input int ch, input int b,
                            input int w, input bit fe, input bit rdy);
    exp_t e;
    cyc++;
    if (!rstn) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_lblk[i] = 0; m_lwht[i] = 0; m_sblk[i] = 0; m_swht[i] = 0;
      end
      m_phase = 0; m_valid = 0; m_ovr = 0;
      sb_q.delete();
      return;
    end
    if (we && ch < NUM_CH) begin
      m_lblk[ch] = acc(m_lblk[ch], b);
      m_lwht[ch] = acc(m_lwht[ch], w);
    end
    case (m_phase)
      0: if (fe) begin
        e.ch = 0; e.score = -1;
        for (int i = 0; i < NUM_CH; i++) begin
          m_sblk[i] = m_lblk[i]; m_swht[i] = m_lwht[i];
          if (m_sblk[i] + m_swht[i] > e.score) begin
            e.score = m_sblk[i] + m_swht[i]; e.ch = i;
          end
        end
        e.due = cyc + NUM_CH + 1;
        sb_q.push_back(e);
        m_phase = 1; m_cnt = 0;
      end
      1: begin
        if (fe) m_ovr = 1;
        m_cnt++;
        if (m_cnt == NUM_CH + 1) begin m_phase = 2; m_valid = 1; end
      end
      default: begin
        if (fe) m_ovr = 1;
        if (rdy) begin m_valid = 0; m_phase = 0; end
      end
    endcase
    if (fe) for (int i = 0; i < NUM_CH; i++) begin m_lblk[i] = 0; m_lwht[i] = 0; end
  endtask

  task automatic step(input bit rstn, input bit we, input int ch, input int b, input int w,
                      input bit fe, input bit rdy, input int rd);
    RESET_N = rstn; WE = we; CH_SEL = SEL_W'(ch);
    confidence_BLK = IN_W'(b); confidence_WHT = IN_W'(w);
    FRAME_END = fe; RESULT_READY = rdy; RD_SEL = SEL_W'(rd);
    @(posedge CLK);
    #1;
    model_edge(rstn, we, ch, b, w, fe, rdy);
  endtask

  task automatic idle(input int n, input bit rdy, input int rd);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, rdy, rd);
  endtask

  // Monitor: pops expected results when the DUT offers one, and tracks status every cycle
  always @(negedge CLK) begin
    if (mon_en) begin
      check("result_valid", longint'(RESULT_VALID), longint'(m_valid));
      check("overrun", longint'(OVERRUN), longint'(m_ovr));
      check("rd_blk", longint'(confidence_BLK_out), m_sblk[RD_SEL]);
      check("rd_wht", longint'(confidence_WHT_out), m_swht[RD_SEL]);
      if (RESULT_VALID && !seen_valid) begin
        seen_valid = 1;
        if (sb_q.size() == 0) begin
          n_checks++; n_errors++; have_cur = 0;
          $display("FAIL unexpected_result: got RESULT_VALID=1, expected no pending result");
        end else begin
          cur = sb_q.pop_front(); have_cur = 1;
          check("latency", cyc, cur.due);
        end
      end
      if (RESULT_VALID && have_cur) begin
        check("best_ch", longint'(BEST_CH), longint'(cur.ch));
        check("best_score", longint'(BEST_SCORE), cur.score);
      end
      if (!RESULT_VALID) seen_valid = 0;
    end
  end

  initial begin
    n_checks = 0; n_errors = 0; cyc = 0; mon_en = 0; have_cur = 0; seen_valid = 0;
    m_phase = 0; m_cnt = 0; m_valid = 0; m_ovr = 0;
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    mon_en = 1;

    // Three samples on ch1, then frame close: best ch1, score 360, readback 300/60
    for (int i = 0; i < 3; i++) step(1, 1, 1, 100, 20, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1, 0, 1);
    idle(7, 0, 1);
    step(1, 0, 0, 0, 0, 0, 1, 1);
    idle(1, 0, 0);

    // Tie between ch0 and ch2 resolves to the lower index
    step(1, 1, 0, 50, 50, 0, 0, 0);
    step(1, 1, 2, 50, 50, 0, 0, 2);
    step(1, 0, 0, 0, 0, 1, 0, 2);
    idle(6, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1, 2);

    // Frame close while scanning: overrun, result unchanged, live bank cleared
    step(1, 1, 3, 9, 9, 1, 0, 3);
    step(1, 1, 1, 40, 40, 0, 0, 1);
    step(1, 1, 1, 40, 40, 1, 0, 1);
    idle(5, 0, 3);
    step(1, 0, 0, 0, 0, 0, 1, 3);
    step(1, 0, 0, 0, 0, 1, 0, 1);
    idle(6, 1, 1);

    // Accumulator limit: 70 full-scale samples on ch3
    for (int i = 0; i < 70; i++) step(1, 1, 3, 1023, 0, 0, 0, 3);
    step(1, 0, 0, 0, 0, 1, 0, 3);
    idle(6, 0, 3);
    step(1, 0, 0, 0, 0, 0, 1, 3);

    // Sample coincident with frame close is kept; reset mid-scan aborts the result
    step(1, 1, 2, 7, 3, 1, 0, 2);
    idle(2, 0, 2);
    step(0, 1, 2, 5, 5, 1, 0, 2);
    idle(8, 1, 2);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      int b;
      b = ($urandom_range(0, 3) == 0) ? 1023 : int'($urandom_range(0, 1023));
      step($urandom_range(0, 399) != 0, $urandom_range(0, 9) < 6,
           int'($urandom_range(0, NUM_CH - 1)), b, int'($urandom_range(0, 1023)),
           $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1,
           int'($urandom_range(0, NUM_CH - 1)));
    end

    idle(NUM_CH + 4, 1, 0);
    idle(2, 0, 0);
    check("sb_drained", longint'(sb_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
